// File: rtl/spi_pkg.sv
// spi_pkg
// Shared definitions for the SPI slave: FSM state encoding, data/byte-count
// widths, the bit-counter width and a helper that builds the mask keeping
// the first N complete bytes of a left-aligned frame.
package spi_pkg;

  localparam int SPI_DATA_W  = 32;
  localparam int SPI_BYTES_W = 3;
  // Bit counter must reach 32 (four full bytes) without wrapping.
  localparam int SPI_CNT_W   = 6;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_ACTIVE    = 2'd2
  } spi_state_e;

  // Ones over the first nbytes bytes counted from bit 31 downward.
  function automatic logic [SPI_DATA_W-1:0] byte_mask(input logic [SPI_BYTES_W-1:0] nbytes);
    logic [5:0] sh;
    sh = {nbytes, 3'b000};
    // A shift of 32 yields all zeros, so four bytes gives a full mask.
    return ~({SPI_DATA_W{1'b1}} >> sh);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// spi_sync
// Multi-flop synchronizer for one asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
//
// Ports:
//   clk_i   system clock
//   rstn_i  asynchronous active-low reset
//   d_i     asynchronous input pin
//   q_o     synchronized level
//   rise_o  one clk_i pulse on a 0->1 transition of q_o
//   fall_o  one clk_i pulse on a 1->0 transition of q_o
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// spi_slave
// SPI mode-0 slave, oversampled by clk_i. Receives up to DATA_BYTES bytes
// per frame (MSB first) and publishes complete bytes left-aligned when slave
// select rises; returns one preloaded 32-bit word on MISO per frame.
//
// Optional feature macro: SPI_SLAVE_OVERRUN_EN -- when defined,
// spi_overrun_o flags a publish that overwrote an unacknowledged frame;
// when undefined spi_overrun_o is tied low.
//
// Ports:
//   clk_i, rstn_i                 system clock, async active-low reset
//   spi_clk_i, spi_ss_i,
//   spi_mosi_i, spi_miso_o        SPI pins (ss active-low)
//   spi_write_data_i/valid_i/
//   ready_o                       load of the tx holding register
//   spi_read_data_o               last frame, first byte in [31:24]
//   spi_read_data_bytes_valid_o   complete bytes in that frame (1..4)
//   spi_read_valid_o, read_ack_i  level valid, cleared by ack pulse
//   spi_overrun_o                 sticky overrun flag
//
// state        | meaning
// ST_WAIT_IDLE | after reset: synchronizers flushing, or ss still low
// ST_IDLE      | ss high, waiting for a frame to start
// ST_ACTIVE    | ss low, shifting on synchronized spi_clk edges
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_BYTES  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   spi_clk_i,
  input  logic                   spi_ss_i,
  input  logic                   spi_mosi_i,
  output logic                   spi_miso_o,
  input  logic [SPI_DATA_W-1:0]  spi_write_data_i,
  input  logic                   spi_write_valid_i,
  output logic                   spi_write_ready_o,
  output logic [SPI_DATA_W-1:0]  spi_read_data_o,
  output logic [SPI_BYTES_W-1:0] spi_read_data_bytes_valid_o,
  output logic                   spi_read_valid_o,
  input  logic                   spi_read_ack_i,
  output logic                   spi_overrun_o
);

  // DATA_BYTES is expected in 1..4.
  localparam logic [SPI_CNT_W-1:0] MAX_BITS     = SPI_CNT_W'(8 * DATA_BYTES);
  localparam logic [7:0]           FLUSH_CYCLES = 8'(SYNC_STAGES + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (spi_clk_i),
    .q_o    (sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (spi_ss_i),
    .q_o    (ss_s),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (spi_mosi_i),
    .q_o    (mosi_s),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  // Frame boundaries are taken from the synchronized ss level so that a
  // missed pulse can never leave the FSM stuck; the pulses are not needed.
  logic unused_edges;
  assign unused_edges = ^{sclk_s, ss_rise, ss_fall, mosi_rise, mosi_fall};

  spi_state_e             state_q;
  logic [7:0]             flush_cnt_q;
  logic                   out_en_q;
  logic [SPI_DATA_W-1:0]  hold_q;
  logic                   hold_full_q;
  logic [SPI_DATA_W-1:0]  tx_q;
  logic [SPI_DATA_W-1:0]  rx_q;
  logic [SPI_CNT_W-1:0]   bitcnt_q;
  logic                   miso_q;
  logic [SPI_DATA_W-1:0]  rd_data_q;
  logic [SPI_BYTES_W-1:0] rd_bytes_q;
  logic                   rd_valid_q;

  logic                   load_acc;
  logic [SPI_BYTES_W-1:0] frame_bytes_d;
  logic                   publish_d;
  logic [SPI_DATA_W-1:0]  rd_data_d;
  logic [4:0]             bit_idx_d;

  always_comb begin
    load_acc      = spi_write_valid_i & spi_write_ready_o;
    frame_bytes_d = bitcnt_q[SPI_CNT_W-1:3];
    publish_d     = (state_q == ST_ACTIVE) && ss_s && (frame_bytes_d != '0);
    // Trailing partial byte is dropped by masking to complete bytes.
    rd_data_d     = rx_q & byte_mask(frame_bytes_d);
    bit_idx_d     = 5'(SPI_DATA_W - 1) - bitcnt_q[4:0];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_WAIT_IDLE;
      flush_cnt_q <= FLUSH_CYCLES;
      out_en_q    <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      bitcnt_q    <= '0;
      miso_q      <= 1'b0;
      rd_data_q   <= '0;
      rd_bytes_q  <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      out_en_q <= 1'b1;
      if (flush_cnt_q != 8'd0) begin
        flush_cnt_q <= flush_cnt_q - 8'd1;
      end

      if (load_acc) begin
        hold_q <= spi_write_data_i;
      end
      hold_full_q <= hold_full_q | load_acc;

      if (publish_d) begin
        rd_data_q  <= rd_data_d;
        rd_bytes_q <= frame_bytes_d;
        rd_valid_q <= 1'b1;
      end else if (spi_read_ack_i) begin
        rd_valid_q <= 1'b0;
      end

      unique case (state_q)
        ST_WAIT_IDLE: begin
          miso_q <= 1'b0;
          // Wait until the ss synchronizer holds real pin samples rather
          // than its reset value, so a frame cut by reset is not resumed.
          if ((flush_cnt_q == 8'd0) && ss_s) begin
            state_q <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          miso_q <= 1'b0;
          if (!ss_s) begin
            state_q  <= ST_ACTIVE;
            tx_q     <= hold_full_q ? hold_q : '0;
            miso_q   <= hold_full_q & hold_q[SPI_DATA_W-1];
            // A load landing in this same cycle can only happen when the
            // register was empty; it is kept for the following frame.
            hold_full_q <= load_acc;
            rx_q     <= '0;
            bitcnt_q <= '0;
          end
        end

        ST_ACTIVE: begin
          if (ss_s) begin
            state_q <= ST_IDLE;
            miso_q  <= 1'b0;
          end else begin
            if (sclk_rise && (bitcnt_q < MAX_BITS)) begin
              rx_q[bit_idx_d] <= mosi_s;
              bitcnt_q        <= bitcnt_q + 1'b1;
            end
            if (sclk_fall) begin
              tx_q   <= tx_q << 1;
              miso_q <= tx_q[SPI_DATA_W-2];
            end
          end
        end

        default: begin
          state_q <= ST_WAIT_IDLE;
          miso_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic ovr_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ovr_q <= 1'b0;
    end else if (publish_d && rd_valid_q) begin
      ovr_q <= 1'b1;
    end else if (spi_read_ack_i) begin
      ovr_q <= 1'b0;
    end
  end

  assign spi_overrun_o = ovr_q;
`else
  assign spi_overrun_o = 1'b0;
`endif

  assign spi_miso_o                  = miso_q;
  assign spi_write_ready_o           = out_en_q & ~hold_full_q;
  assign spi_read_data_o             = rd_data_q;
  assign spi_read_data_bytes_valid_o = rd_bytes_q;
  assign spi_read_valid_o            = rd_valid_q;

endmodule
